// File: rtl/xy_move_sequencer.sv
// Gantry X/Y move sequencer: turns absolute targets or a homing request into
// per-axis direction/step commands and walks X then Y through the go/done handshake.
module xy_move_sequencer #(
  parameter logic [11:0] MAX_X       = 12'd2000,
  parameter logic [11:0] MAX_Y       = 12'd2000,
  parameter logic [11:0] HOME_MARGIN = 12'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic        cmd_home,
  input  logic [11:0] cmd_x,
  input  logic [11:0] cmd_y,
  output logic        cmd_ready,
  output logic        cmd_err,
  output logic        busy,
  output logic        move_done,
  output logic        fault,
  output logic        homed,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic        x_go,
  output logic        x_fwd,
  output logic [11:0] x_steps,
  input  logic        x_done,
  input  logic        x_boundary,
  output logic        y_go,
  output logic        y_fwd,
  output logic [11:0] y_steps,
  input  logic        y_done,
  input  logic        y_boundary
);

  localparam int unsigned W = 12;

  // Homing travel always overshoots the axis length; saturate instead of wrapping.
  localparam logic [W:0]   HX_SUM = {1'b0, MAX_X} + {1'b0, HOME_MARGIN};
  localparam logic [W:0]   HY_SUM = {1'b0, MAX_Y} + {1'b0, HOME_MARGIN};
  localparam logic [W-1:0] HOME_X = HX_SUM[W] ? {W{1'b1}} : HX_SUM[W-1:0];
  localparam logic [W-1:0] HOME_Y = HY_SUM[W] ? {W{1'b1}} : HY_SUM[W-1:0];

  typedef enum logic [3:0] {
    IDLE, X_RUN, X_REL, Y_RUN, Y_REL, HX_RUN, HX_REL, HY_RUN, HY_REL, FIN
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [W-1:0]   x_steps_q, x_steps_d, y_steps_q, y_steps_d;
  logic           x_fwd_q, x_fwd_d, y_fwd_q, y_fwd_d;
  logic           x_go_q, x_go_d, y_go_q, y_go_d;
  logic           bnd_q, bnd_d;
  logic           fault_q, fault_d, homed_q, homed_d;
  logic           cmd_err_q, cmd_err_d, move_done_q, move_done_d;
  logic           cmd_ready_q, cmd_ready_d, busy_q, busy_d;

  logic           x_fwd_cmd, y_fwd_mv;
  logic [W-1:0]   x_steps_cmd, y_steps_mv;

  // Direction and distance for the axis about to start.
  assign x_fwd_cmd   = (cmd_x >= pos_x_q);
  assign x_steps_cmd = x_fwd_cmd ? (cmd_x - pos_x_q) : (pos_x_q - cmd_x);
  assign y_fwd_mv    = (tgt_y_q >= pos_y_q);
  assign y_steps_mv  = y_fwd_mv ? (tgt_y_q - pos_y_q) : (pos_y_q - tgt_y_q);

  always_comb begin
    state_d   = state_q;
    tgt_x_d   = tgt_x_q;
    tgt_y_d   = tgt_y_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    x_steps_d = x_steps_q;
    y_steps_d = y_steps_q;
    x_fwd_d   = x_fwd_q;
    y_fwd_d   = y_fwd_q;
    x_go_d    = x_go_q;
    y_go_d    = y_go_q;
    bnd_d     = bnd_q;
    fault_d   = fault_q;
    homed_d   = homed_q;
    cmd_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_home) begin
            state_d   = HX_RUN;
            x_fwd_d   = 1'b0;
            x_steps_d = HOME_X;
            bnd_d     = 1'b0;
          end else if (!homed_q || (cmd_x > MAX_X) || (cmd_y > MAX_Y)) begin
            cmd_err_d = 1'b1;
          end else begin
            state_d   = X_RUN;
            tgt_x_d   = cmd_x;
            tgt_y_d   = cmd_y;
            x_fwd_d   = x_fwd_cmd;
            x_steps_d = x_steps_cmd;
            bnd_d     = 1'b0;
          end
        end
      end
      X_RUN: begin
        if (x_boundary) bnd_d = 1'b1;
        if (x_steps_q == '0) begin
          state_d   = Y_RUN;
          y_fwd_d   = y_fwd_mv;
          y_steps_d = y_steps_mv;
          bnd_d     = 1'b0;
        end else if (x_go_q && x_done) begin
          x_go_d  = 1'b0;
          state_d = X_REL;
        end else begin
          x_go_d = 1'b1;
        end
      end
      X_REL: begin
        if (bnd_q) begin
          fault_d = 1'b1;
          homed_d = 1'b0;
          state_d = FIN;
        end else begin
          pos_x_d   = tgt_x_q;
          state_d   = Y_RUN;
          y_fwd_d   = y_fwd_mv;
          y_steps_d = y_steps_mv;
          bnd_d     = 1'b0;
        end
      end
      Y_RUN: begin
        if (y_boundary) bnd_d = 1'b1;
        if (y_steps_q == '0) begin
          state_d = FIN;
        end else if (y_go_q && y_done) begin
          y_go_d  = 1'b0;
          state_d = Y_REL;
        end else begin
          y_go_d = 1'b1;
        end
      end
      Y_REL: begin
        if (bnd_q) begin
          fault_d = 1'b1;
          homed_d = 1'b0;
        end else begin
          pos_y_d = tgt_y_q;
        end
        state_d = FIN;
      end
      HX_RUN: begin
        if (x_boundary) bnd_d = 1'b1;
        if (x_go_q && x_done) begin
          x_go_d  = 1'b0;
          state_d = HX_REL;
        end else begin
          x_go_d = 1'b1;
        end
      end
      // Homing succeeds only if the end-stop was actually reached.
      HX_REL: begin
        if (bnd_q) begin
          pos_x_d   = '0;
          state_d   = HY_RUN;
          y_fwd_d   = 1'b0;
          y_steps_d = HOME_Y;
          bnd_d     = 1'b0;
        end else begin
          fault_d = 1'b1;
          homed_d = 1'b0;
          state_d = FIN;
        end
      end
      HY_RUN: begin
        if (y_boundary) bnd_d = 1'b1;
        if (y_go_q && y_done) begin
          y_go_d  = 1'b0;
          state_d = HY_REL;
        end else begin
          y_go_d = 1'b1;
        end
      end
      HY_REL: begin
        if (bnd_q) begin
          pos_y_d = '0;
          homed_d = 1'b1;
          fault_d = 1'b0;
        end else begin
          fault_d = 1'b1;
          homed_d = 1'b0;
        end
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    move_done_d = (state_d == FIN);
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tgt_x_q     <= '0;
      tgt_y_q     <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      x_steps_q   <= '0;
      y_steps_q   <= '0;
      x_fwd_q     <= 1'b0;
      y_fwd_q     <= 1'b0;
      x_go_q      <= 1'b0;
      y_go_q      <= 1'b0;
      bnd_q       <= 1'b0;
      fault_q     <= 1'b0;
      homed_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
      move_done_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      x_steps_q   <= x_steps_d;
      y_steps_q   <= y_steps_d;
      x_fwd_q     <= x_fwd_d;
      y_fwd_q     <= y_fwd_d;
      x_go_q      <= x_go_d;
      y_go_q      <= y_go_d;
      bnd_q       <= bnd_d;
      fault_q     <= fault_d;
      homed_q     <= homed_d;
      cmd_err_q   <= cmd_err_d;
      move_done_q <= move_done_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cmd_err   = cmd_err_q;
  assign busy      = busy_q;
  assign move_done = move_done_q;
  assign fault     = fault_q;
  assign homed     = homed_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign x_go      = x_go_q;
  assign x_fwd     = x_fwd_q;
  assign x_steps   = x_steps_q;
  assign y_go      = y_go_q;
  assign y_fwd     = y_fwd_q;
  assign y_steps   = y_steps_q;

endmodule

// File: doc/xy_move_sequencer.md
Name: xy_move_sequencer

Overview:
- Sequences the two per-axis stepper move units (X, Y) of the gantry. It accepts absolute target coordinates or a homing request and converts each into direction and step counts.
- Drives each axis unit through the go/done handshake: X first, then Y. It tracks the current position and flags boundary faults.
- Sits between the command decoder and the axis move units.

Parameters:
- MAX_X, 12'd2000, largest legal X coordinate in steps.
- MAX_Y, 12'd2000, largest legal Y coordinate in steps.
- HOME_MARGIN, 12'd100, extra steps added to MAX during homing so the boundary is always reached.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command strobe, sampled only while cmd_ready=1
- cmd_home  in  1  1 = homing command (targets ignored), 0 = absolute move
- cmd_x  in  12  target X
- cmd_y  in  12  target Y
- cmd_ready  out  1  high only in IDLE
- cmd_err  out  1  one-cycle pulse when a command is rejected
- busy  out  1  high in every state except IDLE
- move_done  out  1  one-cycle pulse when a command completes (success or fault)
- fault  out  1  sticky; set on unexpected boundary; cleared by successful homing or reset
- homed  out  1  set after successful homing; cleared by fault or reset
- pos_x  out  12  current X position
- pos_y  out  12  current Y position
- x_go  out  1  X unit activate; level, held until x_done
- x_fwd  out  1  X direction (1 = forward/increasing); stable whenever x_go=1
- x_steps  out  12  X step count; stable whenever x_go=1
- x_done  in  1  X unit finished (level, stays high while x_go=1)
- x_boundary  in  1  X end-stop
- y_go, y_fwd, y_steps, y_done, y_boundary: same as X, for the Y axis

Behaviour:
- Reset (async): state=IDLE; cmd_ready=1; all go=0, fwd=0, steps=0; cmd_err=0, move_done=0, fault=0, homed=0, pos_x=pos_y=0.
- States: IDLE, X_RUN, X_REL, Y_RUN, Y_REL, HX_RUN, HX_REL, HY_RUN, HY_REL, FIN.
- IDLE, cmd_valid=1:
  - cmd_home=1 → HX_RUN.
  - cmd_home=0 with (homed=0 or cmd_x>MAX_X or cmd_y>MAX_Y) → cmd_err pulse next cycle; stay IDLE; no go asserted.
  - Otherwise latch the targets and go to X_RUN.
- Move arithmetic, computed at entry to X_RUN/Y_RUN:
  - fwd = (target >= pos).
  - steps = |target − pos|, 12-bit unsigned; no wrap is possible because targets are range-checked.
- X_RUN:
  - If steps==0, skip directly to Y_RUN without asserting x_go.
  - Else x_go=1 from the cycle after entry until x_done is sampled high, then → X_REL.
- X_REL: x_go=0 for exactly one cycle so the axis unit clears its state.
  - Boundary rule: if x_boundary was high in any cycle of X_RUN, set fault=1 and homed=0, leave pos_x unchanged, → FIN (Y is skipped).
  - Else pos_x<=target_x, → Y_RUN.
- Y_RUN / Y_REL: same as X; success → FIN with pos_y<=target_y.
- HX_RUN:
  - x_fwd=0, x_steps=MAX_X+HOME_MARGIN, saturating at 12'hFFF; hold x_go until x_done.
- HX_REL (one cycle, go low):
  - Boundary seen during HX_RUN: pos_x<=0.
  - No boundary: set fault, → FIN.
  - Otherwise → HY_RUN.
- HY_RUN / HY_REL: same as HX for Y. Success sets pos_y=0, homed=1, fault=0, then → FIN.
- FIN: move_done pulses for one cycle; → IDLE (cmd_ready high the following cycle).
- Concurrency: only one axis go is ever high at a time; x_go and y_go are never both 1.
- cmd_valid outside IDLE is ignored, not queued.
- Reset mid-move: all go drop immediately (async). pos, homed and fault return to 0, so homing is required before the next move.
- x_done/y_done seen while the corresponding go=0 are ignored.
- Latency with instant-done units, both axes non-zero: cmd_valid → move_done is 7 cycles; this is a check value only, not a contract.

Test Plan:
- Reset, then move cmd (5,5) → cmd_err pulse, no go asserted, homed=0.
- Home with the model asserting boundary after 30 steps on each axis → x_go then y_go, x_fwd=y_fwd=0, x_steps=y_steps=2100; homed=1, pos=(0,0), one move_done pulse.
- After homing, move (300,120), then (100,120) → first: x_fwd=1/x_steps=300, y_steps=120. Second: x_fwd=0/x_steps=200, y_go never asserted, pos=(100,120).
- Move to (2001,0) while homed → cmd_err, pos unchanged.
- Move (500,500) with x_boundary forced high mid-X → fault=1, homed=0, pos_x unchanged, y_go never asserted, move_done pulses.
- Assert reset while y_go=1 → y_go=0 in the same cycle; pos=(0,0), homed=0, cmd_ready=1.
